// File: rtl/arm_mem_pkg.sv
// Shared encodings for the memory access sequencer: FSM states, bus control
// levels and requester identifiers.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic WB_WORD  = 1'b1;
    localparam logic WB_BYTE  = 1'b0;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the requester granted last loses the next tie.
// The last-grant pointer only moves when the sequencer accepts the grant.
module rr_arbiter2
    import arm_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_id
);

    logic last_q;

    always_comb begin
        grant_valid = req[REQ_FETCH] | req[REQ_DATA];
        grant_id    = REQ_DATA;
        if (req[REQ_FETCH] && req[REQ_DATA]) begin
            grant_id = ~last_q;
        end else if (req[REQ_FETCH]) begin
            grant_id = REQ_FETCH;
        end
    end

    // Resetting to "fetch granted last" gives the data port the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_FETCH;
        end else if (accept) begin
            last_q <= grant_id;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences MAR/MBR/MFA/MFC memory transactions for the fetch and data ports.
// Optional MFC watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_access_sequencer
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic              data_byte,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] MEMADD,
    output logic [DATA_W-1:0] MEMDAT_OUT,
    input  logic [DATA_W-1:0] MEMDAT_IN,
    output logic              MFA,
    output logic              READ_WRITE,
    output logic              WORD_BYTE,
    input  logic              MFC,
    output logic [1:0]        state_dbg
);

    // Requester handshake is 4-phase: req rises and is held, ack rises when the
    // transaction ends, req falls, then ack falls; only then may req rise again.
    state_t      state;
    logic        winner;
    logic        accept;
    logic        grant_valid;
    logic        grant_id;
    logic        winner_req;
    logic [DATA_W-1:0] rd_shaped;

    rr_arbiter2 u_arb (
        .clk         (Clk),
        .rst_n       (Reset),
        .req         ({data_req, fetch_req}),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Requests are ignored while the memory still holds MFC from the last access.
    assign accept     = (state == IDLE) && !MFC && grant_valid;
    assign winner_req = (winner == REQ_DATA) ? data_req : fetch_req;
    assign rd_shaped  = (WORD_BYTE == WB_WORD) ? MEMDAT_IN
                                               : {{(DATA_W-8){1'b0}}, MEMDAT_IN[7:0]};
    assign state_dbg  = state;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            winner      <= REQ_FETCH;
            MFA         <= 1'b0;
            MEMADD      <= '0;
            MEMDAT_OUT  <= '0;
            READ_WRITE  <= RW_READ;
            WORD_BYTE   <= WB_WORD;
            fetch_ack   <= 1'b0;
            data_ack    <= 1'b0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        winner <= grant_id;
                        MFA    <= 1'b1;
                        state  <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (grant_id == REQ_DATA) begin
                            MEMADD     <= data_addr;
                            READ_WRITE <= data_we ? RW_WRITE : RW_READ;
                            WORD_BYTE  <= data_byte ? WB_BYTE : WB_WORD;
                            MEMDAT_OUT <= data_wdata;
                        end else begin
                            MEMADD     <= fetch_addr;
                            READ_WRITE <= RW_READ;
                            WORD_BYTE  <= WB_WORD;
                        end
                    end
                end
                ACCESS: begin
                    if (MFC) begin
                        MFA   <= 1'b0;
                        state <= DONE;
                        if (winner == REQ_DATA) begin
                            data_ack <= 1'b1;
                            if (READ_WRITE == RW_READ) data_rdata <= rd_shaped;
                        end else begin
                            fetch_ack <= 1'b1;
                            if (READ_WRITE == RW_READ) fetch_rdata <= rd_shaped;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        MFA   <= 1'b0;
                        err_q <= 1'b1;
                        state <= DONE;
                        if (winner == REQ_DATA) begin
                            data_ack   <= 1'b1;
                            data_rdata <= '0;
                        end else begin
                            fetch_ack   <= 1'b1;
                            fetch_rdata <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (!winner_req) begin
                        fetch_ack <= 1'b0;
                        data_ack  <= 1'b0;
                        state     <= IDLE;
`ifdef MEM_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
